// File: rtl/pe_row_pkg.sv
// Width helpers shared by the row PE and its adder tree.
// Product and tree-sum widths are derived so that the tree sum can never overflow.
package pe_row_pkg;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int prod_bw(input int data_bw, input int weight_bw);
        return data_bw + weight_bw;
    endfunction

    function automatic int sum_bw(input int data_bw, input int weight_bw, input int lanes);
        return prod_bw(data_bw, weight_bw) + clog2(lanes);
    endfunction

endpackage

// File: rtl/pe_row_acc_sum_tree.sv
// Stage S2: exact signed adder tree over the lane products, registered with a hold enable.
// Nodes are laid out as a heap, so leaves sit at MATRIX_SIZE-1 .. 2*MATRIX_SIZE-2 and the root at 0.
module pe_row_sum_tree
    import pe_row_pkg::*;
#(
    parameter int PROD_BW     = 16,
    parameter int MATRIX_SIZE = 8,
    parameter int SUM_BW      = PROD_BW + clog2(MATRIX_SIZE)
) (
    input  logic                            clk,
    input  logic                            i_en,
    input  logic [MATRIX_SIZE*PROD_BW-1:0]  i_prod,
    output logic signed [SUM_BW-1:0]        o_sum
);

    logic signed [SUM_BW-1:0] w_sum;
    logic signed [SUM_BW-1:0] r_sum_p2;

    always_comb begin
        logic signed [SUM_BW-1:0] node [2*MATRIX_SIZE-1];
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            node[MATRIX_SIZE-1+i] = SUM_BW'($signed(i_prod[i*PROD_BW +: PROD_BW]));
        end
        for (int i = MATRIX_SIZE - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        w_sum = node[0];
    end

    // ---- S2 register ----
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_sum_p2 <= w_sum;
        end
    end

    assign o_sum = r_sum_p2;

endmodule

// File: rtl/pe_row_acc.sv
// Pipelined row PE: double-buffered weights, lane products (S1), adder tree (S2),
// saturating K-tile accumulator (S3) and an output register behind a valid/ready pair.
module pe_row_acc
    import pe_row_pkg::*;
#(
    parameter int DATA_BW     = 8,
    parameter int WEIGHT_BW   = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int ACC_BW      = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              w_wr_en,
    input  logic [WEIGHT_BW*MATRIX_SIZE-1:0]  w_wr_data,
    input  logic                              w_swap,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]    in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [ACC_BW-1:0]          out_data,
    output logic                              out_sat
);

    localparam int PROD_BW = prod_bw(DATA_BW, WEIGHT_BW);
    localparam int SUM_BW  = sum_bw(DATA_BW, WEIGHT_BW, MATRIX_SIZE);

    function automatic logic sat_ovf(input logic signed [ACC_BW:0] v);
        return v[ACC_BW] != v[ACC_BW-1];
    endfunction

    function automatic logic signed [ACC_BW-1:0] sat_acc(input logic signed [ACC_BW:0] v);
        if (!sat_ovf(v)) begin
            return v[ACC_BW-1:0];
        end
        return v[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
    endfunction

    logic [WEIGHT_BW*MATRIX_SIZE-1:0] r_wt_shadow;
    logic [WEIGHT_BW*MATRIX_SIZE-1:0] r_wt_active;

    logic                             r_in_rdy;
    logic                             w_stall;
    logic                             w_adv;
    logic                             w_accept;

    logic [MATRIX_SIZE*PROD_BW-1:0]   w_prod;
    logic [MATRIX_SIZE*PROD_BW-1:0]   r_prod_p1;
    logic                             r_vld_p1;
    logic                             r_last_p1;

    logic signed [SUM_BW-1:0]         w_sum_p2;
    logic                             r_vld_p2;
    logic                             r_last_p2;

    logic signed [ACC_BW-1:0]         r_acc_p3;
    logic                             r_sat_p3;
    logic                             r_vld_p3;
    logic                             r_last_p3;
    logic                             r_first;

    logic signed [ACC_BW-1:0]         w_acc_base;
    logic signed [ACC_BW:0]           w_acc_wide;
    logic signed [ACC_BW-1:0]         w_acc_next;
    logic                             w_clamp;
    logic                             w_sat_next;

    logic                             r_out_valid;
    logic signed [ACC_BW-1:0]         r_out_data;
    logic                             r_out_sat;

    assign w_stall  = r_out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = r_in_rdy && w_adv;
    assign w_accept = in_valid && in_ready;

    // A simultaneous write and swap makes the incoming row active immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wt_shadow <= '0;
            r_wt_active <= '0;
        end else begin
            if (w_wr_en) begin
                r_wt_shadow <= w_wr_data;
            end
            if (w_swap) begin
                r_wt_active <= w_wr_en ? w_wr_data : r_wt_shadow;
            end
        end
    end

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            logic signed [PROD_BW-1:0] v_d;
            logic signed [PROD_BW-1:0] v_w;
            v_d = PROD_BW'($signed(in_data[i*DATA_BW +: DATA_BW]));
            v_w = PROD_BW'($signed(r_wt_active[i*WEIGHT_BW +: WEIGHT_BW]));
            w_prod[i*PROD_BW +: PROD_BW] = v_d * v_w;
        end
    end

    // ---- S1: lane products ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_prod_p1 <= w_prod;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_rdy  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else begin
            r_in_rdy <= 1'b1;
            if (w_adv) begin
                r_vld_p1  <= w_accept;
                r_last_p1 <= in_last;
                r_vld_p2  <= r_vld_p1;
                r_last_p2 <= r_last_p1;
            end
        end
    end

    // ---- S2: tree sum ----
    pe_row_sum_tree #(
        .PROD_BW     (PROD_BW),
        .MATRIX_SIZE (MATRIX_SIZE),
        .SUM_BW      (SUM_BW)
    ) u_sum_tree (
        .clk    (clk),
        .i_en   (w_adv),
        .i_prod (r_prod_p1),
        .o_sum  (w_sum_p2)
    );

    // r_acc_p3 keeps the last result; r_first makes the next beat start a fresh accumulation.
    always_comb begin
        w_acc_base = r_first ? '0 : r_acc_p3;
        w_acc_wide = (ACC_BW+1)'(w_acc_base) + (ACC_BW+1)'(w_sum_p2);
        w_clamp    = sat_ovf(w_acc_wide);
        w_acc_next = sat_acc(w_acc_wide);
        w_sat_next = (!r_first && r_sat_p3) || w_clamp;
    end

    // ---- S3: accumulator, then output register ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc_p3    <= '0;
            r_sat_p3    <= 1'b0;
            r_vld_p3    <= 1'b0;
            r_last_p3   <= 1'b0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_vld_p3  <= r_vld_p2;
            r_last_p3 <= r_last_p2;
            if (r_vld_p2) begin
                r_acc_p3 <= w_acc_next;
                r_sat_p3 <= w_sat_next;
                r_first  <= r_last_p2;
            end
            r_out_valid <= r_vld_p3 && r_last_p3;
            if (r_vld_p3 && r_last_p3) begin
                r_out_data <= r_acc_p3;
                r_out_sat  <= r_sat_p3;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_pe_row_acc.sv
// Bench for pe_row_acc: directed scenarios plus randomized beats, scored against a queue-based model.
`timescale 1ns/1ps
module tb_pe_row_acc;

    localparam int DW  = 8;
    localparam int WW  = 8;
    localparam int MS  = 8;
    localparam int ACC = 20;
    localparam longint AMAX = (longint'(1) <<< (ACC - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC - 1));

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  w_wr_en = 1'b0;
    logic [WW*MS-1:0]      w_wr_data = '0;
    logic                  w_swap = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DW*MS-1:0]      in_data = '0;
    logic                  in_last = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [ACC-1:0] out_data;
    logic                  out_sat;

    always #5 clk = ~clk;

    pe_row_acc #(
        .DATA_BW     (DW),
        .WEIGHT_BW   (WW),
        .MATRIX_SIZE (MS),
        .ACC_BW      (ACC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .w_wr_en   (w_wr_en),
        .w_wr_data (w_wr_data),
        .w_swap    (w_swap),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    typedef struct {
        logic signed [ACC-1:0] data;
        bit                    sat;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     rand_bp = 0;
    int     m_act[MS];
    int     m_sh[MS];
    longint m_acc = 0;
    bit     m_sticky = 0;

    function automatic logic [DW*MS-1:0] bcast(input int v);
        logic [DW*MS-1:0] r;
        for (int i = 0; i < MS; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MS; i++) begin
            m_act[i] = 0;
            m_sh[i]  = 0;
        end
        m_acc = 0;
        m_sticky = 0;
        exp_q.delete();
    endtask

    // Dot product against the weights active at acceptance, saturating running sum.
    task automatic model_accept(input logic [DW*MS-1:0] d, input bit last);
        longint dot;
        longint s;
        exp_t   e;
        dot = 0;
        for (int i = 0; i < MS; i++) dot += longint'($signed(d[i*DW +: DW])) * longint'(m_act[i]);
        s = m_acc + dot;
        if (s > AMAX) begin
            s = AMAX;
            m_sticky = 1;
        end else if (s < AMIN) begin
            s = AMIN;
            m_sticky = 1;
        end
        if (last) begin
            e.data = ACC'(s);
            e.sat  = m_sticky;
            exp_q.push_back(e);
            m_acc = 0;
            m_sticky = 0;
        end else begin
            m_acc = s;
        end
    endtask

    task automatic model_weights(input bit wen, input bit wsw, input logic [WW*MS-1:0] wd);
        if (wen) for (int i = 0; i < MS; i++) m_sh[i] = int'($signed(wd[i*WW +: WW]));
        if (wsw) for (int i = 0; i < MS; i++) m_act[i] = m_sh[i];
    endtask

    task automatic wset(input int v, input bit swap);
        w_wr_en = 1'b1;
        w_swap = swap;
        w_wr_data = bcast(v);
        @(posedge clk);
        model_weights(1'b1, swap, bcast(v));
        #1;
        w_wr_en = 1'b0;
        w_swap = 1'b0;
    endtask

    task automatic beat(input logic [DW*MS-1:0] d, input bit last, input bit wen,
                        input bit wsw, input logic [WW*MS-1:0] wd);
        bit ok;
        bit first;
        ok = 0;
        first = 1;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        w_wr_en = wen;
        w_swap = wsw;
        w_wr_data = wd;
        for (int c = 0; c < 300; c++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ok = in_ready;
            @(posedge clk);
            if (ok) model_accept(d, last);
            if (first) model_weights(wen, wsw, wd);
            #1;
            if (first) begin
                w_wr_en = 1'b0;
                w_swap = 1'b0;
            end
            first = 0;
            if (ok) break;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, required acceptance");
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input string name, input longint d, input bit s);
        int c;
        c = 0;
        while (!out_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got out_valid=0 for 20 cycles, required 1", name);
        end else begin
            check({name, "_data"}, longint'(out_data), d);
            check({name, "_sat"}, longint'(out_sat), longint'(s));
        end
    endtask

    // Monitor: every handshake on the output side is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got out_data=%0d out_sat=%0b, required no output", out_data, out_sat);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_sat !== e.sat) begin
                        n_err++;
                        $display("FAIL sb_result: got %0d/sat %0b, required %0d/sat %0b", out_data, out_sat, e.data, e.sat);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Legacy per-beat mode with exact three-edge latency
        wset(2, 1'b1);
        beat(bcast(1), 1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("legacy_valid_edge%0d", k), longint'(out_valid), (k == 3) ? 1 : 0);
        end
        check("legacy_data", longint'(out_data), 16);
        check("legacy_sat", longint'(out_sat), 0);
        idle(4);

        // K tiling over four beats
        wset(1, 1'b1);
        for (int b = 1; b <= 4; b++) beat(bcast(b), b == 4, 1'b0, 1'b0, '0);
        wait_out("tiling", 80, 0);
        idle(4);

        // Swap in the acceptance cycle of beat A only affects beat B
        wset(1, 1'b1);
        wset(3, 1'b0);
        beat(bcast(1), 1'b1, 1'b0, 1'b1, '0);
        beat(bcast(1), 1'b1, 1'b0, 1'b0, '0);
        wait_out("dbuf_a", 8, 0);
        @(posedge clk);
        #1;
        check("dbuf_b_valid", longint'(out_valid), 1);
        check("dbuf_b_data", longint'(out_data), 24);
        idle(4);

        // Saturation, then a fresh accumulation clears the sticky flag
        wset(-128, 1'b1);
        for (int b = 1; b <= 5; b++) beat(bcast(-128), b == 5, 1'b0, 1'b0, '0);
        wait_out("sat", 524287, 1);
        idle(2);
        beat(bcast(-128), 1'b1, 1'b0, 1'b0, '0);
        wait_out("sat_next", 131072, 0);
        idle(4);

        // Backpressure with three back-to-back results
        wset(1, 1'b1);
        out_ready = 1'b0;
        beat(bcast(5), 1'b1, 1'b0, 1'b0, '0);
        beat(bcast(6), 1'b1, 1'b0, 1'b0, '0);
        beat(bcast(7), 1'b1, 1'b0, 1'b0, '0);
        idle(3);
        check("bp_in_ready", longint'(in_ready), 0);
        check("bp_hold_valid", longint'(out_valid), 1);
        check("bp_hold_data", longint'(out_data), 40);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_second", longint'(out_data), 48);
        @(posedge clk);
        #1;
        check("bp_third", longint'(out_data), 56);
        check("bp_third_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        check("bp_drained", longint'(out_valid), 0);
        idle(2);

        // Randomized beats, weight traffic and backpressure
        rand_bp = 1;
        for (int n = 0; n < 250; n++) begin
            bit wen;
            bit wsw;
            logic [WW*MS-1:0] wd;
            logic [DW*MS-1:0] dd;
            wen = ($urandom_range(0, 7) == 0);
            wsw = ($urandom_range(0, 9) == 0);
            wd = {$urandom, $urandom};
            dd = {$urandom, $urandom};
            beat(dd, $urandom_range(0, 2) == 0, wen, wsw, wd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        beat(bcast(1), 1'b1, 1'b0, 1'b0, '0);
        rand_bp = 0;
        out_ready = 1'b1;
        idle(10);
        check("rand_drained", longint'(exp_q.size()), 0);

        // Reset mid-accumulation discards the partial sum
        for (int pass = 0; pass < 2; pass++) begin
            wset(1, 1'b1);
            beat(bcast(3), 1'b0, 1'b0, 1'b0, '0);
            beat(bcast(3), 1'b0, 1'b0, 1'b0, '0);
            idle(1);
            rstn = 1'b0;
            model_reset();
            #2;
            check("midrst_in_ready", longint'(in_ready), 0);
            check("midrst_out_valid", longint'(out_valid), 0);
            check("midrst_out_data", longint'(out_data), 0);
            check("midrst_out_sat", longint'(out_sat), 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rstn = 1'b1;
            @(posedge clk);
            #1;
            if (pass == 0) begin
                beat(bcast(1), 1'b1, 1'b0, 1'b0, '0);
                wait_out("after_rst_zero_wt", 0, 0);
            end else begin
                wset(1, 1'b1);
                beat(bcast(1), 1'b1, 1'b0, 1'b0, '0);
                wait_out("after_rst_fresh", 8, 0);
            end
            idle(4);
        end

        idle(6);
        check("final_queue_empty", longint'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_row_acc.md
# pe_row_acc

Parametrised, pipelined successor to the single-row PE. It computes the dot product of one MATRIX_SIZE-lane signed data vector with a double-buffered weight row. Partial sums accumulate over a variable number of input beats (K-dimension tiling) with signed saturation. It sits between the input data skew/feeder and the output collection buffer, and moves data through valid/ready handshakes on both sides.

## Interface
- DATA_BW, 8, signed data lane width
- WEIGHT_BW, 8, signed weight lane width
- MATRIX_SIZE, 8, lane count; power of two, ≥2
- ACC_BW, 32, accumulator/output width; must be ≥ SUM_BW
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- w_wr_en  in  1  write w_wr_data into shadow weight bank
- w_wr_data  in  WEIGHT_BW*MATRIX_SIZE  weight row, lane i at [i*WEIGHT_BW +: WEIGHT_BW]
- w_swap  in  1  copy shadow bank into active bank
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat
- in_data  in  DATA_BW*MATRIX_SIZE  data row, same lane packing as weights
- in_last  in  1  beat is final tile of current accumulation
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  ACC_BW  signed saturated accumulated dot product
- out_sat  out  1  saturation occurred anywhere in this accumulation

## Operation
- Derived widths: PROD_BW = DATA_BW+WEIGHT_BW; SUM_BW = PROD_BW+clog2(MATRIX_SIZE). Tree sum is exact, with no overflow possible.
- A beat is accepted when in_valid && in_ready. Lane products use the active bank value at the acceptance edge.
- Weight banks:
  - w_wr_en writes the shadow bank.
  - w_swap sets active ← shadow.
  - If w_wr_en and w_swap occur in the same cycle, active ← w_wr_data and shadow ← w_wr_data.
  - A swap in the acceptance cycle of a beat affects only later beats.
- Pipeline stages:
  - S1 registers the MATRIX_SIZE products.
  - S2 registers the tree sum, sign-extended to SUM_BW.
  - S3 is the accumulator.
- Accumulator:
  - The first beat after reset, or after a last beat, starts from 0. Later beats add to acc.
  - Addition is done at ACC_BW+1 bits, then saturated to [−2^(ACC_BW−1), 2^(ACC_BW−1)−1].
  - sat_sticky is set on any clamp.
  - When the S3 beat has in_last set: out_data ← saturated result, out_sat ← sat_sticky|clamp, out_valid ← 1, then acc and sat_sticky clear.
- Non-last beats produce no output.
- Stall:
  - stall = out_valid && !out_ready. While stalled, all stages, acc and out regs hold, and in_ready = 0.
  - Otherwise in_ready = 1.
  - Weight writes and swaps are never stalled.
- out_valid drops on handshake unless a new last beat completes in the same cycle, in which case it stays 1 with new data.
- in_last=1 on every beat gives a plain per-beat dot product (legacy mode).

## Timing
- Reset values: in_ready 0 during reset and 1 after; out_valid 0, out_data 0, out_sat 0; both weight banks 0; acc 0; all stage valids 0.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+3 when unstalled.
- Throughput: one beat per cycle.
- Stall cycles add 1:1 latency.
- rstn asserted mid-accumulation discards everything in flight and the partial acc, with no output.
- in_valid=0 bubbles propagate and do not touch acc.

## Structure
- Package pe_row_pkg holds a clog2 function and the PROD_BW/SUM_BW width helper functions.
- Sub-module pe_row_sum_tree holds the combinational signed adder tree over MATRIX_SIZE PROD_BW inputs with a registered SUM_BW output and hold enable (stage S2).
- The top level holds the weight banks, S1 products, accumulator FSM-free control (first-flag, sat_sticky) and the output register.

## Test plan
All scenarios use MATRIX_SIZE=8 and DATA_BW=WEIGHT_BW=8 unless noted.
- Legacy mode: weights all 2 (write+swap), data all 1, in_last=1 → out_data=16 three cycles after accept, out_sat=0.
- Tiling: 4 beats (data 1..4 broadcast on all lanes, weights 1), in_last on 4th → single output 80. No output for beats 1–3.
- Double buffer: swap to weights 3 in the same cycle as accepting beat A (data 1, last); next beat B (data 1, last) → outputs 8 (old weights 1), then 24.
- Saturation with ACC_BW=20: data −128, weights −128, 5 beats, last on 5th → out_data=524287, out_sat=1. The next accumulation of one beat → 131072, out_sat=0.
- Backpressure: out_ready=0 with 3 back-to-back last beats → in_ready falls, nothing is lost; releasing out_ready delivers the three results in order at one per cycle.
- Reset mid-accumulation: 2 non-last beats, then rstn low → all outputs 0. After release, 1 last beat (data 1, weights 0) → 0.
